// File: rtl/sw_sb_ctrl.sv
// sw_sb_ctrl: bus-mapped switch input peripheral with debounce, change flags and IRQ handshake.
//   clk_i, rst              clock, synchronous active-high reset
//   addr_i, req_i,
//   write_data_i,
//   write_enable_i          bus request (byte offset, 1 = write)
//   read_data_o             registered read data, holds between reads
//   sw_i                    raw asynchronous switch levels
//   interrupt_request_o     high while the IRQ FSM is PENDING
//   interrupt_return_i      one-cycle pulse from the handler when done
module sw_sb_ctrl #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic [31:0]         addr_i,
    input  logic                req_i,
    input  logic [31:0]         write_data_i,
    input  logic                write_enable_i,
    output logic [31:0]         read_data_o,
    input  logic [SW_WIDTH-1:0] sw_i,
    output logic                interrupt_request_o,
    input  logic                interrupt_return_i
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    logic [SW_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, deb_q, deb_d;
    logic [SW_WIDTH-1:0] mask_q, mask_d, flags_q, flags_d, flag_set, flag_clr;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    state_t              state_q, state_d;
    logic                wr, rd, soft_rst;

    always_comb begin
        wr       = req_i & write_enable_i;
        rd       = req_i & ~write_enable_i;
        soft_rst = wr && addr_i == 32'h24 && write_data_i == 32'd1;
        s1_d     = sw_i;
        s2_d     = s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        deb_d    = deb_q;
        flag_set = '0;
        // One shared counter: any change on any bit restarts the stability window.
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX && cand_q != deb_q) begin
            deb_d    = cand_q;
            flag_set = cand_q ^ deb_q;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        flag_clr = (wr && addr_i == 32'h0C ? write_data_i[SW_WIDTH-1:0] : '0)
                 | (state_q == PENDING && interrupt_return_i ? mask_q : '0);
        // New changes win over any clear landing on the same bit.
        flags_d  = (flags_q & ~flag_clr) | flag_set;
        mask_d   = wr && addr_i == 32'h04 ? write_data_i[SW_WIDTH-1:0] : mask_q;
        rdata_d  = !rd                ? rdata_q
                 : addr_i == 32'h00   ? 32'(deb_q)
                 : addr_i == 32'h04   ? 32'(mask_q)
                 : addr_i == 32'h08   ? 32'(flags_q)
                 : addr_i == 32'h0C   ? 32'd0
                 :                      32'hDEAD_BEEF;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && (flags_q & mask_q) != '0)
            state_d = PENDING;
        else if (state_q == PENDING && interrupt_return_i)
            state_d = IDLE;
    end

    always_comb begin
        interrupt_request_o = state_q == PENDING;
        read_data_o         = rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst || soft_rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
            mask_q  <= '0;
            flags_q <= '0;
            rdata_q <= '0;
            state_q <= IDLE;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            mask_q  <= mask_d;
            flags_q <= flags_d;
            rdata_q <= rdata_d;
            state_q <= state_d;
        end
    end
endmodule
